pc_stack_unit: RTL and testbench
================================

# pc_stack_unit

Parametrised program-counter and return-address-stack unit for the next-generation single-cycle core. It holds the PC and computes the next PC from four sources: increment, absolute jump, PC-relative branch, and return. It owns a hardware call stack with depth and error tracking. It replaces the fixed 12-bit PC register, incrementer, offset adder, PC-source mux and stack of the current datapath. It adds stall, signed branch offsets, and sticky overflow/underflow detection.

## Interface
- PC_W, 12, PC and instruction-address width in bits
- OFS_W, 8, branch offset width in bits (OFS_W ≤ PC_W)
- DEPTH, 8, return-stack entries (≥ 2)
- RESET_PC, 0, PC value after reset
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- stall  input  1  hold all state this cycle
- pc_sel  input  2  next-PC source: 00 plus1, 01 jump, 10 branch, 11 return
- push  input  1  push pc_plus1 onto stack (call)
- jump_addr  input  PC_W  absolute target for pc_sel=01
- offset  input  OFS_W  branch offset for pc_sel=10
- err_clr  input  1  clear sticky error flags
- pc  output  PC_W  current PC (registered)
- pc_plus1  output  PC_W  pc+1 mod 2^PC_W (combinational)
- sp  output  $clog2(DEPTH+1)  number of valid stack entries
- stack_empty  output  1  sp==0
- stack_full  output  1  sp==DEPTH
- overflow  output  1  sticky: push attempted while full
- underflow  output  1  sticky: return attempted while empty

## Operation
- Next PC, per pc_sel:
  - plus1 → pc+1.
  - jump → jump_addr.
  - branch → pc+1 + ext(offset).
  - return → stack top when not empty, else pc+1.
- All PC arithmetic is modulo 2^PC_W. Carries out are discarded.
- Call = pc_sel=01 with push=1. The return address pushed is pc_plus1 of the calling cycle.
- push with pc_sel≠11:
  - If not full: write pc_plus1 at index sp, then sp+1.
  - If full: the entry is dropped, sp is unchanged, overflow is set. The PC update still happens.
- pc_sel=11, push=0:
  - If not empty: next PC = entry[sp-1], then sp-1.
  - If empty: underflow is set, sp stays 0.
- pc_sel=11 with push=1 (swap):
  - If not empty: next PC = old top, top is overwritten with pc_plus1, sp is unchanged, no flags change.
  - If empty: underflow is set, next PC = pc+1, and pc_plus1 is pushed (sp becomes 1).
- stall=1: pc, sp, stack contents and flags all hold. push, pc_sel and err_clr are ignored.
- err_clr=1 clears both flags. If a set event occurs in the same cycle, set wins.
- Stack storage is not reset. Contents above sp are don't-care.

## Timing
- pc, sp and flags are all registered and update on the rising clk edge. Latency from select inputs to pc is 1 cycle.
- pc_plus1, stack_empty and stack_full are combinational from registered state.
- The stack top read is combinational. A return takes effect on the next edge with no extra cycle.
- rst overrides everything, including stall, and may arrive mid-call sequence. After the reset edge:
  - pc=RESET_PC
  - sp=0
  - stack_empty=1, stack_full=0
  - overflow=0, underflow=0

## Configuration
- PC_STACK_SIGNED_OFS_EN defined:
  - ext(offset) sign-extends offset from OFS_W to PC_W.
  - Backward branches are supported.
- Not defined: ext(offset) zero-extends, which is the legacy forward-only behaviour of the current core.
- No other behaviour differs.

## Test plan
All scenarios use PC_W=12, OFS_W=8, DEPTH=4.
- Reset, then 3 cycles of plus1 → pc 0x000, 0x001, 0x002, 0x003; sp=0, stack_empty=1, both flags 0.
- Jump to 0xFFF, then plus1 → pc=0xFFF, then wraps to 0x000.
- From pc=0x010, branch with offset=0xFE:
  - Macro defined → pc=0x00F.
  - Macro undefined → pc=0x10F.
- Four calls from pc 0x100, 0x200, 0x300, 0x400 (call targets = next call site):
  - After the fourth call, sp=4 and stack_full=1.
  - A fifth call sets overflow=1, leaves sp at 4, and still jumps.
  - Four returns yield pc 0x401, 0x301, 0x201, 0x101.
- Return on empty at pc=0x050 → pc=0x051, underflow=1, sp=0.
  - err_clr → underflow=0.
  - err_clr held together with a second empty return → underflow stays 1.
- With sp=1 and top=0x101, at pc=0x300:
  - stall=1 with call asserted → pc, sp and top unchanged.
  - Then pc_sel=11 with push=1 → pc=0x101, sp=1, top=0x301.

Source files
------------

// File: rtl/pc_stack_unit.sv
// pc_stack_unit
//
// Program counter with next-PC selection and a hardware return-address stack.
// Each cycle the next PC comes from one of four sources: increment, absolute
// jump, PC-relative branch, or the top of the return stack. Calls push the
// address of the following instruction. The stack tracks its depth and raises
// sticky overflow and underflow flags.
//
// Build option:
//   PC_STACK_SIGNED_OFS_EN  when defined, the branch offset is sign-extended,
//                           which allows backward branches. When undefined, it
//                           is zero-extended, giving forward-only branches.
//
// Parameters:
//   PC_W      PC / instruction-address width
//   OFS_W     branch offset width (OFS_W <= PC_W)
//   DEPTH     return-stack entries (>= 2)
//   RESET_PC  PC value loaded by reset
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset; overrides stall
//   stall        hold pc, sp, stack contents and flags this cycle
//   pc_sel       next-PC source: 00 plus1, 01 jump, 10 branch, 11 return
//   push         push pc_plus1 onto the stack (call); with pc_sel=11, swap
//   jump_addr    absolute target for pc_sel=01
//   offset       branch offset for pc_sel=10
//   err_clr      clear sticky overflow/underflow (a same-cycle set wins)
//   pc           current PC (registered)
//   pc_plus1     pc + 1, wrapping (combinational)
//   sp           number of valid stack entries
//   stack_empty  sp == 0
//   stack_full   sp == DEPTH
//   overflow     sticky: push attempted while full
//   underflow    sticky: return attempted while empty

module pc_stack_unit #(
    parameter int              PC_W     = 12,
    parameter int              OFS_W    = 8,
    parameter int              DEPTH    = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         stall,
    input  logic [1:0]                   pc_sel,
    input  logic                         push,
    input  logic [PC_W-1:0]              jump_addr,
    input  logic [OFS_W-1:0]             offset,
    input  logic                         err_clr,
    output logic [PC_W-1:0]              pc,
    output logic [PC_W-1:0]              pc_plus1,
    output logic [$clog2(DEPTH+1)-1:0]   sp,
    output logic                         stack_empty,
    output logic                         stack_full,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int SP_W  = $clog2(DEPTH+1);
    localparam int IDX_W = $clog2(DEPTH);

    localparam logic [1:0] SEL_PLUS1  = 2'b00;
    localparam logic [1:0] SEL_JUMP   = 2'b01;
    localparam logic [1:0] SEL_BRANCH = 2'b10;
    localparam logic [1:0] SEL_RETURN = 2'b11;

    // Widen the branch offset to PC width. Signedness is a build option.
    function automatic logic signed [PC_W-1:0] ext_ofs(input logic [OFS_W-1:0] ofs);
        logic signed [OFS_W-1:0] ofs_s;
        logic signed [PC_W-1:0]  ext;
        ofs_s = ofs;
`ifdef PC_STACK_SIGNED_OFS_EN
        ext = PC_W'(ofs_s);
`else
        ext = $signed(PC_W'(ofs));
`endif
        return ext;
    endfunction

    // Return-address storage; not reset, entries at or above sp are don't-care.
    logic [PC_W-1:0] stack_mem [DEPTH];

    logic [IDX_W-1:0] top_idx;
    logic [IDX_W-1:0] push_idx;
    logic [PC_W-1:0]  stack_top;
    logic [PC_W-1:0]  branch_tgt;

    logic [PC_W-1:0]  pc_next;
    logic [SP_W-1:0]  sp_next;
    logic             ovf_set;
    logic             unf_set;
    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;

    assign pc_plus1    = pc + PC_W'(1);
    assign stack_empty = (sp == '0);
    assign stack_full  = (sp == SP_W'(DEPTH));

    // Only meaningful when the stack is non-empty / non-full respectively;
    // the truncation is safe under those guards.
    assign top_idx    = IDX_W'(sp - SP_W'(1));
    assign push_idx   = IDX_W'(sp);
    assign stack_top  = stack_mem[top_idx];
    assign branch_tgt = pc_plus1 + $unsigned(ext_ofs(offset));

    always_comb begin
        pc_next = pc_plus1;
        sp_next = sp;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        wr_en   = 1'b0;
        wr_idx  = push_idx;

        case (pc_sel)
            SEL_PLUS1:  pc_next = pc_plus1;
            SEL_JUMP:   pc_next = jump_addr;
            SEL_BRANCH: pc_next = branch_tgt;
            SEL_RETURN: pc_next = stack_empty ? pc_plus1 : stack_top;
            default:    pc_next = pc_plus1;
        endcase

        if (pc_sel != SEL_RETURN) begin
            if (push) begin
                if (stack_full) begin
                    // Return address is dropped; the PC update still proceeds.
                    ovf_set = 1'b1;
                end else begin
                    wr_en   = 1'b1;
                    wr_idx  = push_idx;
                    sp_next = sp + SP_W'(1);
                end
            end
        end else if (!push) begin
            if (stack_empty) begin
                unf_set = 1'b1;
            end else begin
                sp_next = sp - SP_W'(1);
            end
        end else begin
            // Return with push: swap the top for the new return address.
            if (stack_empty) begin
                // Nothing to pop, but the push still lands in slot 0.
                unf_set = 1'b1;
                wr_en   = 1'b1;
                wr_idx  = '0;
                sp_next = SP_W'(1);
            end else begin
                wr_en   = 1'b1;
                wr_idx  = top_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc        <= RESET_PC;
            sp        <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (!stall) begin
            pc        <= pc_next;
            sp        <= sp_next;
            // Set takes priority over a same-cycle clear.
            overflow  <= ovf_set | (overflow  & ~err_clr);
            underflow <= unf_set | (underflow & ~err_clr);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !stall && wr_en) begin
            stack_mem[wr_idx] <= pc_plus1;
        end
    end

endmodule

// File: tb/tb_pc_stack_unit.sv
module tb_pc_stack_unit;

    localparam int PC_W  = 12;
    localparam int OFS_W = 8;
    localparam int DEPTH = 4;
    localparam int SP_W  = $clog2(DEPTH+1);

    logic              clk = 1'b0;
    logic              rst;
    logic              stall;
    logic [1:0]        pc_sel;
    logic              push;
    logic [PC_W-1:0]   jump_addr;
    logic [OFS_W-1:0]  offset;
    logic              err_clr;
    logic [PC_W-1:0]   pc;
    logic [PC_W-1:0]   pc_plus1;
    logic [SP_W-1:0]   sp;
    logic              stack_empty;
    logic              stack_full;
    logic              overflow;
    logic              underflow;

    int checks = 0;
    int errors = 0;

    pc_stack_unit #(
        .PC_W(PC_W), .OFS_W(OFS_W), .DEPTH(DEPTH), .RESET_PC(12'h000)
    ) dut (
        .clk(clk), .rst(rst), .stall(stall), .pc_sel(pc_sel), .push(push),
        .jump_addr(jump_addr), .offset(offset), .err_clr(err_clr),
        .pc(pc), .pc_plus1(pc_plus1), .sp(sp), .stack_empty(stack_empty),
        .stack_full(stack_full), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall = 0; pc_sel = 2'b00; push = 0; err_clr = 0;
        jump_addr = '0; offset = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        tick();
        rst = 0;
        checks++; if (pc !== 12'h000) begin errors++; $display("FAIL reset_pc got %h exp %h", pc, 12'h000); end
        checks++; if (sp !== 3'd0) begin errors++; $display("FAIL reset_sp got %0d exp 0", sp); end
        checks++; if (stack_empty !== 1'b1 || stack_full !== 1'b0) begin errors++; $display("FAIL reset_empty_full got %b%b exp 10", stack_empty, stack_full); end
        checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin errors++; $display("FAIL reset_flags got %b%b exp 00", overflow, underflow); end
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++; if (pc !== 12'(i)) begin errors++; $display("FAIL plus1_%0d got %h exp %h", i, pc, 12'(i)); end
        end
    endtask

    task automatic test_jump_wrap();
        pc_sel = 2'b01; jump_addr = 12'hFFF;
        tick();
        checks++; if (pc !== 12'hFFF) begin errors++; $display("FAIL jump_fff got %h exp fff", pc); end
        checks++; if (pc_plus1 !== 12'h000) begin errors++; $display("FAIL pc_plus1_wrap got %h exp 000", pc_plus1); end
        pc_sel = 2'b00;
        tick();
        checks++; if (pc !== 12'h000) begin errors++; $display("FAIL wrap_pc got %h exp 000", pc); end
    endtask

    task automatic test_branch();
        logic [PC_W-1:0] exp_pc;
`ifdef PC_STACK_SIGNED_OFS_EN
        exp_pc = 12'h00F;
`else
        exp_pc = 12'h10F;
`endif
        pc_sel = 2'b01; jump_addr = 12'h010;
        tick();
        pc_sel = 2'b10; offset = 8'hFE;
        tick();
        checks++; if (pc !== exp_pc) begin errors++; $display("FAIL branch_fe got %h exp %h", pc, exp_pc); end
        // Small forward branch is the same in both builds: 0x010 + 1 + 3.
        pc_sel = 2'b01; jump_addr = 12'h010;
        tick();
        pc_sel = 2'b10; offset = 8'h03;
        tick();
        checks++; if (pc !== 12'h014) begin errors++; $display("FAIL branch_03 got %h exp 014", pc); end
    endtask

    task automatic test_calls();
        logic [PC_W-1:0] ret_exp [4];
        ret_exp[0] = 12'h401; ret_exp[1] = 12'h301; ret_exp[2] = 12'h201; ret_exp[3] = 12'h101;
        pc_sel = 2'b01; push = 0; jump_addr = 12'h100;
        tick();
        push = 1;
        for (int i = 1; i <= 4; i++) begin
            jump_addr = 12'((i + 1) * 12'h100);
            tick();
            checks++; if (pc !== jump_addr || sp !== 3'(i)) begin errors++; $display("FAIL call_%0d got pc %h sp %0d exp pc %h sp %0d", i, pc, sp, jump_addr, i); end
        end
        checks++; if (stack_full !== 1'b1 || overflow !== 1'b0) begin errors++; $display("FAIL full_after_4 got full %b ovf %b exp 1 0", stack_full, overflow); end
        jump_addr = 12'h600;
        tick();
        checks++; if (overflow !== 1'b1 || sp !== 3'd4 || pc !== 12'h600) begin errors++; $display("FAIL call_5_ovf got ovf %b sp %0d pc %h exp 1 4 600", overflow, sp, pc); end
        push = 0; pc_sel = 2'b11;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (pc !== ret_exp[i] || sp !== 3'(3 - i)) begin errors++; $display("FAIL return_%0d got pc %h sp %0d exp pc %h sp %0d", i, pc, sp, ret_exp[i], 3 - i); end
        end
        checks++; if (stack_empty !== 1'b1 || overflow !== 1'b1) begin errors++; $display("FAIL after_returns got empty %b ovf %b exp 1 1", stack_empty, overflow); end
        pc_sel = 2'b00; err_clr = 1;
        tick();
        err_clr = 0;
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clr got %b exp 0", overflow); end
    endtask

    task automatic test_underflow();
        pc_sel = 2'b01; jump_addr = 12'h050;
        tick();
        pc_sel = 2'b11;
        tick();
        checks++; if (pc !== 12'h051 || underflow !== 1'b1 || sp !== 3'd0) begin errors++; $display("FAIL ret_empty got pc %h unf %b sp %0d exp 051 1 0", pc, underflow, sp); end
        pc_sel = 2'b00; err_clr = 1;
        tick();
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL unf_clr got %b exp 0", underflow); end
        pc_sel = 2'b11; err_clr = 1;
        tick();
        err_clr = 0;
        checks++; if (underflow !== 1'b1 || pc !== 12'h053) begin errors++; $display("FAIL set_wins got unf %b pc %h exp 1 053", underflow, pc); end
    endtask

    task automatic test_stall_swap();
        pc_sel = 2'b01; push = 0; jump_addr = 12'h100;
        tick();
        push = 1; jump_addr = 12'h300;
        tick();
        checks++; if (pc !== 12'h300 || sp !== 3'd1) begin errors++; $display("FAIL setup_call got pc %h sp %0d exp 300 1", pc, sp); end
        stall = 1; jump_addr = 12'h700; err_clr = 1;
        tick();
        tick();
        checks++; if (pc !== 12'h300 || sp !== 3'd1 || underflow !== 1'b1) begin errors++; $display("FAIL stall_hold got pc %h sp %0d unf %b exp 300 1 1", pc, sp, underflow); end
        stall = 0; err_clr = 0; pc_sel = 2'b11; push = 1;
        tick();
        checks++; if (pc !== 12'h101 || sp !== 3'd1) begin errors++; $display("FAIL swap got pc %h sp %0d exp 101 1", pc, sp); end
        push = 0;
        tick();
        checks++; if (pc !== 12'h301 || sp !== 3'd0) begin errors++; $display("FAIL swap_top got pc %h sp %0d exp 301 0", pc, sp); end
        err_clr = 1; pc_sel = 2'b00;
        tick();
        err_clr = 0; pc_sel = 2'b11; push = 1;
        tick();
        checks++; if (pc !== 12'h303 || sp !== 3'd1 || underflow !== 1'b1) begin errors++; $display("FAIL swap_empty got pc %h sp %0d unf %b exp 303 1 1", pc, sp, underflow); end
        push = 0;
        tick();
        checks++; if (pc !== 12'h303 || sp !== 3'd0) begin errors++; $display("FAIL swap_empty_pop got pc %h sp %0d exp 303 0", pc, sp); end
    endtask

    task automatic test_reset_mid();
        pc_sel = 2'b01; push = 1; jump_addr = 12'h200;
        tick();
        stall = 1; rst = 1;
        tick();
        rst = 0;
        checks++; if (pc !== 12'h000 || sp !== 3'd0 || overflow !== 1'b0 || underflow !== 1'b0) begin errors++; $display("FAIL reset_mid got pc %h sp %0d ovf %b unf %b exp 000 0 0 0", pc, sp, overflow, underflow); end
        idle_inputs();
        tick();
        checks++; if (pc !== 12'h001) begin errors++; $display("FAIL post_reset got %h exp 001", pc); end
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        test_reset();
        test_jump_wrap();
        test_branch();
        test_calls();
        test_underflow();
        test_stall_swap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
